// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: branch resolve, req/ack data-memory port, MEM/WB register
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_branch,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] inAdder,
  input  logic              inZf,
  input  logic [DATA_W-1:0] inOutAlu,
  input  logic [DATA_W-1:0] inRD2,
  input  logic [REG_W-1:0]  inMux5b,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] branch_target,
  output logic              addr_err,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [DATA_W-1:0] wb_read_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [REG_W-1:0]  wb_rd
);

  typedef enum logic {IDLE, WAIT} stateT;

  stateT state, nextState;

  logic             memOp;
  logic             aligned;
  logic             heldRegWrite;
  logic             heldMemToReg;
  logic [REG_W-1:0] heldRd;

  assign memOp         = in_valid & (in_mem_read | in_mem_write);
  assign aligned       = (inOutAlu[1:0] == 2'b00);
  assign pc_src        = in_valid & in_branch & inZf;
  assign branch_target = inAdder;

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    if (state == IDLE) begin
      if (memOp && aligned) begin
        stall     = 1'b1;
        nextState = WAIT;
      end
    end else begin
      if (mem_ack) begin
        nextState = IDLE;
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      addr_err      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_rd         <= '0;
      heldRegWrite  <= 1'b0;
      heldMemToReg  <= 1'b0;
      heldRd        <= '0;
    end else begin
      state    <= nextState;
      addr_err <= 1'b0;
      if (state == IDLE) begin
        if (!memOp) begin
          wb_valid      <= in_valid;
          wb_reg_write  <= in_reg_write;
          wb_mem_to_reg <= in_mem_to_reg;
          wb_read_data  <= '0;
          wb_alu_result <= inOutAlu;
          wb_rd         <= inMux5b;
        end else if (aligned) begin
          mem_req      <= 1'b1;
          mem_we       <= in_mem_write;
          mem_addr     <= inOutAlu;
          mem_wdata    <= inRD2;
          heldRegWrite <= in_reg_write;
          heldMemToReg <= in_mem_to_reg;
          heldRd       <= inMux5b;
          wb_valid     <= 1'b0;
        end else begin
          // Misaligned: retire without touching memory and without a register write.
          addr_err      <= 1'b1;
          wb_valid      <= 1'b1;
          wb_reg_write  <= 1'b0;
          wb_mem_to_reg <= in_mem_to_reg;
          wb_read_data  <= '0;
          wb_alu_result <= inOutAlu;
          wb_rd         <= inMux5b;
        end
      end else begin
        if (mem_ack) begin
          mem_req       <= 1'b0;
          wb_valid      <= 1'b1;
          wb_reg_write  <= heldRegWrite;
          wb_mem_to_reg <= heldMemToReg;
          wb_read_data  <= mem_we ? '0 : mem_rdata;
          wb_alu_result <= mem_addr;
          wb_rd         <= heldRd;
        end else begin
          wb_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline: consumer of the EX/MEM bundle (branch target, zero flag, ALU result, store data, destination register) and producer of the MEM/WB bundle. Resolves branches, drives a request/acknowledge data-memory port for loads and stores, and stalls the upstream stages while an access is outstanding. Results are registered into the MEM/WB outputs on the rising edge.

## Interface
- DATA_W, 32, data/address width
- REG_W, 5, register-index width
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  EX/MEM bundle holds a real instruction (0 = bubble)
- in_mem_read / in_mem_write  input  1 each  load / store (never both)
- in_branch  input  1  conditional branch
- in_reg_write, in_mem_to_reg  input  1 each  writeback controls, passed through
- inAdder  input  DATA_W  branch target
- inZf  input  1  ALU zero flag
- inOutAlu  input  DATA_W  ALU result / memory address
- inRD2  input  DATA_W  store data
- inMux5b  input  REG_W  destination register
- mem_req  output  1  memory request, registered
- mem_we  output  1  1 = write, registered
- mem_addr, mem_wdata  output  DATA_W  registered, stable while mem_req=1
- mem_rdata  input  DATA_W  read data, valid with mem_ack
- mem_ack  input  1  single-cycle completion
- stall  output  1  hold IF/ID/EX and the EX/MEM bundle
- pc_src  output  1  take branch
- branch_target  output  DATA_W  equals inAdder
- addr_err  output  1  misaligned access, one-cycle pulse, registered
- wb_valid, wb_reg_write, wb_mem_to_reg  output  1 each
- wb_read_data, wb_alu_result  output  DATA_W
- wb_rd  output  REG_W

## Operation
- States: IDLE, WAIT.
- mem_op = in_valid & (in_mem_read | in_mem_write); aligned = inOutAlu[1:0]==0.
- IDLE, no mem_op: on edge load wb_* from bundle (wb_valid=in_valid, wb_read_data=0); stay IDLE.
- IDLE, mem_op & aligned: stall=1; on edge set mem_req=1, mem_we=in_mem_write, mem_addr=inOutAlu, mem_wdata=inRD2; wb_valid<=0; go WAIT.
- IDLE, mem_op & !aligned: no request; stall=0; on edge addr_err<=1, wb_valid<=1, wb_reg_write<=0, other wb_* from bundle.
- WAIT, mem_ack=0: stall=1; mem_* held; wb_valid<=0.
- WAIT, mem_ack=1: stall=0; on edge mem_req<=0, wb_read_data<=mem_rdata (load) or 0 (store), wb_* from held bundle, wb_valid<=1; go IDLE.
- mem_ack in IDLE: ignored.
- pc_src = in_valid & in_branch & inZf, combinational, independent of state; branch_target = inAdder.
- stall combinational: (IDLE & mem_op & aligned) | (WAIT & !mem_ack).
- Widths exact; no arithmetic beyond alignment check.

## Timing
- Reset: state IDLE; mem_req, mem_we, addr_err, all wb_* flags 0; mem_addr, mem_wdata, wb_read_data, wb_alu_result, wb_rd 0.
- Reset in WAIT: mem_req 0 after the reset edge; a late mem_ack is ignored; no wb_valid produced.
- Non-memory instruction sampled at edge N: wb_* valid after edge N (latency 1).
- Memory instruction present cycle N: mem_req high from edge N; mem_ack k≥0 cycles later (cycle N+1+k); stall high cycles N..N+k (k+1 cycles); wb_valid=1 for one cycle after the ack edge.
- addr_err is high exactly one cycle after the offending edge.
- Upstream holds the bundle stable whenever stall=1.

## Test plan
- Reset then ALU op (in_valid=1, inOutAlu=0x0000_0010, inMux5b=5, in_reg_write=1) -> next cycle wb_valid=1, wb_alu_result=0x10, wb_rd=5, mem_req=0, stall=0.
- Load addr 0x0000_0040, ack after 3 wait cycles with mem_rdata=0xDEAD_BEEF -> stall high 4 cycles, mem_req/mem_addr stable, wb_read_data=0xDEAD_BEEF with wb_valid one cycle.
- Store addr 0x0000_0008 data 0x1234_5678, ack same cycle as mem_req rises -> stall 1 cycle, mem_we=1, wb_valid=1 with wb_read_data=0.
- Store to 0x0000_0006 -> no mem_req, addr_err pulses 1 cycle, wb_reg_write=0, stall=0.
- Branch inZf=1, inAdder=0x0000_0100 -> pc_src=1, branch_target=0x100 same cycle; inZf=0 -> pc_src=0.
- Assert rst during WAIT, then ack next cycle -> mem_req=0 after reset edge, wb_valid stays 0, state IDLE.
